// File: rtl/comp_pkg.sv
// Shared definitions for the 4-bit magnitude comparator and its operand loader.
package comp_pkg;

  localparam int DEF_WIDTH = 4;

  // Loader FSM states; the encoding is also shown on the board LEDs.
  // Encoding 2'b11 is unused.
  typedef enum logic [1:0] {
    ST_WAIT_A = 2'b00,
    ST_WAIT_B = 2'b01,
    ST_READY  = 2'b10
  } state_e;

  // Comparator result codes.
  localparam logic [1:0] CMP_EQ = 2'b11;
  localparam logic [1:0] CMP_GT = 2'b10;
  localparam logic [1:0] CMP_LT = 2'b01;

  // Result code the comparator produces for a given operand pair.
  function automatic logic [1:0] cmp_result(input logic [DEF_WIDTH-1:0] a,
                                            input logic [DEF_WIDTH-1:0] b);
    if (a == b)     return CMP_EQ;
    else if (a > b) return CMP_GT;
    else            return CMP_LT;
  endfunction

endpackage

// File: rtl/debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and
// rising-edge detect. `level` is the debounced button, `press` pulses for
// one clock when the debounced level goes high.
module debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic in_raw,
  output logic level,
  output logic press
);

  // Wide enough to hold DB_CYCLES-1 even when DB_CYCLES is 1.
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync_q,  sync_d;
  logic          level_q, level_d;
  logic          prev_q,  prev_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Synchronize, then accept a new level only after DB_CYCLES consecutive
  // clocks of disagreement; any agreement restarts the count.
  always_comb begin
    sync1_d = in_raw;
    sync_d  = sync1_q;
    prev_d  = level_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers; reset clears everything, including a count in progress.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = level_q & ~prev_q;

endmodule

// File: rtl/comp_operand_loader.sv
// Operand capture for the magnitude comparator: one switch bank, one button.
// Each debounced press loads the switches into A, then B; `valid` is high
// while a complete pair is held. A press from READY starts a new pair by
// reloading A while B keeps its old value.
module comp_operand_loader
  import comp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DB_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] SW,
  input  logic             load,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             valid,
  output logic [1:0]       state_led
);

  logic             load_level;
  logic             press;

  logic [WIDTH-1:0] sw_s1_q, sw_s1_d;
  logic [WIDTH-1:0] sw_s_q,  sw_s_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;

  debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .in_raw  (load),
    .level   (load_level),
    .press   (press)
  );

  // Capture FSM. `press` implies the debounced level is high; qualifying
  // with the level keeps captures tied to the button actually being down.
  always_comb begin
    sw_s1_d = SW;
    sw_s_d  = sw_s1_q;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_WAIT_A: begin
        if (press && load_level) begin
          a_d     = sw_s_q;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (press && load_level) begin
          b_d     = sw_s_q;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (press && load_level) begin
          a_d     = sw_s_q;
          state_d = ST_WAIT_B;
        end
      end
      default: state_d = ST_WAIT_A;
    endcase
    valid_d = (state_d == ST_READY);
  end

  // Registers; reset takes priority over a press in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_s1_q <= '0;
      sw_s_q  <= '0;
      state_q <= ST_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s_q  <= sw_s_d;
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign valid     = valid_q;
  assign state_led = state_q;

endmodule

// File: tb/tb_comp_operand_loader.sv
// Bench for comp_operand_loader with a short debounce window.
module tb_comp_operand_loader;
  import comp_pkg::*;

  localparam int W  = 4;
  localparam int DB = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] sw;
  logic [W-1:0] a, b;
  logic         valid;
  logic [1:0]   state_led;

  always #10 clk = ~clk;

  comp_operand_loader #(
    .WIDTH    (W),
    .DB_CYCLES(DB)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .SW       (sw),
    .load     (load),
    .A        (a),
    .B        (b),
    .valid    (valid),
    .state_led(state_led)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs are seen two clocks late; the button level flips once the last DB
  // delayed samples all disagree with it; each rising flip is one press that
  // advances the A -> B -> ready cycle using the switches seen with it.
  logic [W-1:0] exp_q[$];
  bit           m_ls_pipe[2];
  logic [W-1:0] m_sw_pipe[2];
  bit           m_hist[$];
  bit           m_level, m_prev, m_press, m_all_differ;
  int           m_mode;
  logic [W-1:0] m_a, m_b;

  always @(posedge clk) begin
    if (reset) begin
      m_ls_pipe = '{0, 0};
      m_sw_pipe = '{'0, '0};
      m_hist.delete();
      exp_q.delete();
      m_level = 0;
      m_prev  = 0;
      m_mode  = 0;
      m_a     = '0;
      m_b     = '0;
    end else begin
      m_press = m_level && !m_prev;
      if (m_press) begin
        if (m_mode == 1) begin
          m_b = m_sw_pipe[1];
          m_mode = 2;
        end else begin
          m_a = m_sw_pipe[1];
          m_mode = 1;
        end
        exp_q.push_back(m_sw_pipe[1]);
      end
      m_prev = m_level;
      m_hist.push_back(m_ls_pipe[1]);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      if (m_hist.size() == DB) begin
        m_all_differ = 1;
        foreach (m_hist[i]) if (m_hist[i] == m_level) m_all_differ = 0;
        if (m_all_differ) m_level = m_ls_pipe[1];
      end
      m_ls_pipe[1] = m_ls_pipe[0];
      m_ls_pipe[0] = load;
      m_sw_pipe[1] = m_sw_pipe[0];
      m_sw_pipe[0] = sw;
    end
  end

  // ---------------- scoreboard ----------------
  // Cycle-by-cycle comparison against the model, plus a capture monitor that
  // matches every observed capture against the queued expected operand.
  logic [1:0]   prev_led = 2'b00;
  logic [W-1:0] exp_val;

  always @(negedge clk) begin
    check_eq("a_step",     a,         m_a);
    check_eq("b_step",     b,         m_b);
    check_eq("valid_step", valid,     (m_mode == 2));
    check_eq("state_step", state_led, m_mode[1:0]);
    if (state_led != prev_led && state_led != 2'b00) begin
      check_eq("capture_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_val = exp_q.pop_front();
        check_eq("capture_value", (state_led == 2'b01) ? a : b, exp_val);
      end
    end
    prev_led = state_led;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [W-1:0] val, input int hi, input int lo);
    sw   = val;
    load = 1'b1;
    tick(hi);
    load = 1'b0;
    tick(lo);
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] ea,
                               input logic [W-1:0] eb, input logic ev,
                               input logic [1:0] es);
    check_eq({tag, "_a"},     a,         ea);
    check_eq({tag, "_b"},     b,         eb);
    check_eq({tag, "_valid"}, valid,     ev);
    check_eq({tag, "_state"}, state_led, es);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    load  = 1'b0;
    sw    = '0;
    tick(3);
    check_outputs("reset", 4'd0, 4'd0, 1'b0, 2'b00);
    reset = 1'b0;
    tick(2);

    // Normal load: A captured exactly 7 clocks after load rises.
    sw   = 4'd9;
    load = 1'b1;
    tick(6);
    check_eq("a_before_latency", a, 4'd0);
    tick(1);
    check_eq("a_at_latency", a, 4'd9);
    check_eq("state_after_a", state_led, 2'b01);
    tick(1);
    load = 1'b0;
    tick(8);
    pulse(4'd5, 8, 8);
    check_outputs("pair", 4'd9, 4'd5, 1'b1, 2'b10);
    check_eq("cmp_gt", cmp_result(a, b), CMP_GT);

    // Bounce rejection.
    for (int i = 0; i < 10; i++) begin
      load = (i % 2 == 0);
      sw   = W'($urandom_range(0, 15));
      tick(2);
    end
    load = 1'b0;
    tick(10);
    check_outputs("bounce", 4'd9, 4'd5, 1'b1, 2'b10);

    // Reload from READY.
    pulse(4'd3, 8, 8);
    check_outputs("reload_a", 4'd3, 4'd5, 1'b0, 2'b01);
    pulse(4'd3, 8, 8);
    check_outputs("reload_b", 4'd3, 4'd3, 1'b1, 2'b10);
    check_eq("cmp_eq", cmp_result(a, b), CMP_EQ);

    // Held button: one capture only, switches moving after the press.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sw    = 4'd6;
    load  = 1'b1;
    tick(10);
    for (int i = 0; i < 30; i++) begin
      sw = W'($urandom_range(0, 15));
      tick(1);
    end
    check_outputs("held", 4'd6, 4'd0, 1'b0, 2'b01);
    load = 1'b0;
    tick(10);

    // Reset in the middle of a debounce, button kept down through it.
    sw   = 4'hC;
    load = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    check_outputs("mid_reset", 4'd0, 4'd0, 1'b0, 2'b00);
    reset = 1'b0;
    tick(12);
    check_outputs("held_through_reset", 4'hC, 4'd0, 1'b0, 2'b01);
    load = 1'b0;
    tick(10);

    // Randomized button activity with occasional resets.
    for (int i = 0; i < 300; i++) begin
      sw    = W'($urandom_range(0, 15));
      load  = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 59) == 0);
      tick($urandom_range(1, 9));
      reset = 1'b0;
    end
    load = 1'b0;
    tick(12);
    check_eq("captures_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/comp_operand_loader.md
# comp_operand_loader

Upstream operand-capture stage for the 4-bit magnitude comparator. It lets one bank of switches load both comparator operands in turn. A debounced push-button captures the switch value as operand A, then as operand B. Once both operands are captured, it asserts `valid`, and the comparator's 2-bit result is meaningful from then on. It drives the comparator's `A`/`B` inputs directly.

## Interface

Parameters:
- `WIDTH`, 4: operand width in bits; must match the comparator.
- `DB_CYCLES`, 500000: the synchronized button must be stable for this many consecutive clocks before it is accepted (10 ms at 50 MHz). Minimum 1.

Ports:
- `CLOCK_50`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `SW`  in  WIDTH  raw switch value to capture.
- `load`  in  1  raw, asynchronous, bouncy push-button level, active-high.
- `A`  out  WIDTH  captured operand A; goes to comparator input A.
- `B`  out  WIDTH  captured operand B; goes to comparator input B.
- `valid`  out  1  high while A and B both hold a completed pair.
- `state_led`  out  2  current FSM state encoding, for the board LEDs.

## Operation

- `SW` and `load` each pass through a 2-flop synchronizer. The synchronized signals are `sw_s` and `load_s`.
- Debouncer:
  - Holds a registered debounced level `load_d` and a counter.
  - The counter increments on each clock where `load_s != load_d`.
  - The counter clears on any clock where `load_s == load_d`.
  - When the counter reaches `DB_CYCLES-1` while `load_s` still differs, `load_d` takes `load_s` and the counter clears.
- Edge detect:
  - `press = load_d & ~load_d_prev` is a one-cycle pulse.
  - Release edges are ignored.
- FSM, with `state_led` encoding shown in brackets:
  - WAIT_A [00]: on `press`, `A <= sw_s` and go to WAIT_B.
  - WAIT_B [01]: on `press`, `B <= sw_s` and go to READY; `valid` rises.
  - READY [10]: on `press`, `A <= sw_s`, `B` is held, `valid` falls, and go to WAIT_B.
  - Encoding 11 is unused. Any illegal state returns to WAIT_A on the next clock.
- `valid` is registered and equals (state == READY).
- Reset values: `A = 0`, `B = 0`, `valid = 0`, `state_led = 00`, state WAIT_A. Synchronizer flops, `load_d`, `load_d_prev` and the counter are all 0.

## Timing

- Latency: `load` rises at edge 0 and is held. Then:
  - `load_s` goes high after edge 2.
  - `load_d` goes high after edge 2+`DB_CYCLES`.
  - The `A`/`B`/`valid` update is visible after edge 3+`DB_CYCLES`.
- Glitches: a `load` pulse or bounce shorter than `DB_CYCLES` synchronized cycles produces no `press` and no state change.
- Held button: holding `load` produces exactly one `press`. Another capture requires release; release debouncing takes a further `DB_CYCLES` cycles.
- Captured value: the operand captured is `sw_s` in the `press` cycle, i.e. `SW` as it was 2 clocks earlier. `SW` changes at any other time do not affect A or B.
- Reset mid-operation: reset has priority over `press` in the same cycle. Everything returns to its reset values on the next edge, including a debounce count in progress. A button held through reset deassertion registers as a press `DB_CYCLES` cycles after `load_s` is seen high.

## Structure

- A shared package `comp_pkg` holds:
  - the state encoding constants (`ST_WAIT_A`, `ST_WAIT_B`, `ST_READY`);
  - the default `WIDTH`;
  - the comparator result codes: 11 equal, 10 A>B, 01 A<B.
- One sub-module, `debounce`, contains:
  - the synchronizer, counter and edge detect;
  - parameter `DB_CYCLES`;
  - ports `CLOCK_50`, `reset`, `in_raw`, `level`, `press`.
- The `SW` synchronizer and the FSM stay in the top module.

## Test plan

All scenarios run with `DB_CYCLES`=4.
- Reset: hold `reset` for 3 cycles -> `A`=0, `B`=0, `valid`=0, `state_led`=00.
- Normal load: `SW`=9, pulse `load` for 8 cycles, release for 8; then `SW`=5, same pulse.
  - After the first pulse: `A`=9 at exactly cycle 7 after `load` rises, `state_led`=01.
  - After the second pulse: `B`=5, `valid`=1, `state_led`=10, and the comparator output is 10.
- Bounce rejection: toggle `load` 1/0 every 2 cycles for 20 cycles, then drop it low -> no change to `A`, `B` or state.
- Held button: hold `load` high for 40 cycles -> exactly one capture, state WAIT_B only.
- Reload from READY: from READY with A=9 and B=5, load `SW`=3.
  - `A`=3, `valid`=0, `B` still 5.
  - Then load `SW`=3 -> `valid`=1 and the comparator output is 11.
- Reset mid-debounce: assert `reset` at cycle 4 of a `load` press -> no capture; all outputs are at their reset values on the next clock.
